rv_instr_encoder_loader: RTL and testbench
==========================================

Name: rv_instr_encoder_loader

Overview:
- Encoder counterpart to the RV32I opcode decoder: accepts instruction descriptors (class plus register, function and immediate fields) over a valid/ready stream.
- Packs each descriptor into a 32-bit RV32I word and writes it sequentially into the instruction memory write port.
- Used by the test harness and the boot path to load programs before the single-cycle core runs.
- Only the five classes the decoder supports are encoded: R-type, load, store, branch, I-type ALU.

Parameters:
- ADDR_WIDTH, 6, width of the instruction memory word address.
- DEPTH, 64, maximum number of words per load session (1..2^ADDR_WIDTH).
- BASE_ADDR, 0, word address of the first write in a session.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load session; ignored while in LOAD.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  high only in LOAD; a transfer occurs when in_valid && in_ready.
- in_class  input  3  0=R (0110011), 1=LOAD (0000011), 2=STORE (0100011), 3=BRANCH (1100011), 4=IALU (0010011); 5-7 invalid.
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field, used by R only.
- in_imm  input  12  imm[11:0] for LOAD, IALU and STORE; branch offset bits [12:1] for BRANCH.
- in_last  input  1  descriptor is the last one in the session.
- mem_we  output  1  one-cycle write strobe.
- mem_addr  output  ADDR_WIDTH  word write address.
- mem_wdata  output  32  encoded instruction word.
- count  output  ADDR_WIDTH+1  number of words written this session.
- busy  output  1  state == LOAD.
- done  output  1  state == DONE.
- err  output  1  sticky flag: an invalid class was accepted this session.

Behaviour:
- Reset (synchronous) forces state IDLE and drives every output 0: in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err.
- Reset mid-session aborts the session; no further writes occur.
- FSM transitions:
  - IDLE: start -> LOAD. On that edge, write pointer = BASE_ADDR, count = 0, err = 0.
  - LOAD:
    - in_ready = 1.
    - An accepted valid-class descriptor produces exactly one write on the following cycle: mem_we = 1, mem_addr = pointer, mem_wdata = encoded word. The pointer then increments and count increments.
    - Latency is 1 cycle, and one descriptor can be accepted per cycle (full throughput). mem_addr and mem_wdata are registered and hold their last values when mem_we = 0.
  - LOAD -> DONE when the accepted descriptor has in_last = 1, or when that accept makes count reach DEPTH (in_last ignored). in_ready drops in the cycle after that accept; the final write still issues.
  - DONE: done = 1 is held. start -> LOAD begins a new session with a full reinitialisation.
- Encoding formats (bit fields, MSB first):
  - R: funct7 | rs2 | rs1 | funct3 | rd | 0110011.
  - LOAD / IALU: imm[11:0] | rs1 | funct3 | rd | opcode. funct7 and rs2 are ignored.
  - STORE: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | 0100011. rd is ignored.
  - BRANCH, with i = in_imm = offset[12:1]: i[11] | i[9:4] | rs2 | rs1 | funct3 | i[3:0] | i[10] | 1100011.
- Invalid class (5-7): the descriptor is consumed with no write and no count change, and err is set and stays set. If it carries in_last, the FSM still goes to DONE.
- Address arithmetic: pointer = BASE_ADDR + count, modulo 2^ADDR_WIDTH (wraps silently).
- Handshake edge cases:
  - in_valid while not in LOAD is ignored.
  - start and an accept in the same LOAD cycle: start is ignored.
  - start in the same cycle as reset: reset wins.

Test Plan:
- Reset with random inputs -> all outputs 0, in_ready = 0, and no mem_we for 5 cycles.
- start; R class, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, in_last=0 -> one cycle after accept: mem_we = 1, mem_addr = 0, mem_wdata = 0x002081B3; count = 1.
- Back-to-back accepts with in_valid held: LOAD rd=5 rs1=2 funct3=2 imm=8 -> 0x00812283 at addr 1; STORE rs2=5 rs1=2 funct3=2 imm=12 -> 0x00512623 at addr 2, written on consecutive cycles.
- BRANCH rs1=1 rs2=2 funct3=0 in_imm=0xFFE (offset -4), in_last=1 -> 0x00208EE3 with the sign bits set, i.e. 0xFE208EE3, at addr 3; then done = 1, in_ready = 0, count = 4.
- New session with class 6 and in_last = 1 -> no mem_we, err = 1, count = 0, done = 1.
- DEPTH=4 override, stream 4 IALU descriptors with in_last = 0 -> writes at addrs 0-3, then done and in_ready = 0. Repeat the stream with reset asserted after 2 accepts -> at most those 2 writes, then IDLE with all outputs 0.

Source files
------------

// File: rtl/rv_instr_encoder_loader.sv
// rtl/rv_instr_encoder_loader.sv - packs RV32I instruction descriptors and streams them into instruction memory
module rv_instr_encoder_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_class,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [11:0]           in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   count_inc;
  logic                  accept;
  logic                  class_ok;
  logic                  final_accept;
  logic [31:0]           enc_word;

  assign accept    = in_valid && (state == S_LOAD);
  assign class_ok  = (in_class <= 3'd4);
  assign count_inc = count + CNT_ONE;
  // The session ends on in_last from any class, or on the write that fills DEPTH.
  assign final_accept = accept && (in_last || (class_ok && (count_inc == CNT_DEPTH)));

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD);
  assign done     = (state == S_DONE);

  // Pack the descriptor fields into the RV32I format selected by the class.
  always_comb begin
    enc_word = 32'd0;
    case (in_class)
      3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'd1: enc_word = {in_imm, in_rs1, in_funct3, in_rd, 7'b0000011};
      3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      3'd3: enc_word = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                        in_imm[3:0], in_imm[10], 7'b1100011};
      3'd4: enc_word = {in_imm, in_rs1, in_funct3, in_rd, 7'b0010011};
      default: enc_word = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only honoured outside LOAD.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: if (final_accept) state_nxt = S_DONE;
      S_DONE: if (start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write port, pointer, count and sticky error; one write per accepted valid descriptor.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if ((state != S_LOAD) && start) begin
        ptr   <= PTR_BASE;
        count <= '0;
        err   <= 1'b0;
      end else if (accept) begin
        if (class_ok) begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_wdata <= enc_word;
          ptr       <= ptr + PTR_ONE;
          count     <= count_inc;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder_loader.sv
// tb/tb_rv_instr_encoder_loader.sv - randomized self-checking bench for rv_instr_encoder_loader
module tb_rv_instr_encoder_loader;

  localparam int AW = 6;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, in_last;
  logic [2:0]  in_class, in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [6:0]  in_funct7;
  logic [11:0] in_imm;

  logic          rdy [NI];
  logic          we  [NI];
  logic          bsy [NI];
  logic          dn  [NI];
  logic          er  [NI];
  logic [AW-1:0] addr[NI];
  logic [31:0]   wd  [NI];
  logic [AW:0]   cnt [NI];

  // u0: defaults, u1: short sessions, u2: base near the top so the pointer wraps
  rv_instr_encoder_loader #(.ADDR_WIDTH(AW), .DEPTH(64), .BASE_ADDR(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wd[0]), .count(cnt[0]),
    .busy(bsy[0]), .done(dn[0]), .err(er[0]));

  rv_instr_encoder_loader #(.ADDR_WIDTH(AW), .DEPTH(4), .BASE_ADDR(0)) u1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wd[1]), .count(cnt[1]),
    .busy(bsy[1]), .done(dn[1]), .err(er[1]));

  rv_instr_encoder_loader #(.ADDR_WIDTH(AW), .DEPTH(8), .BASE_ADDR(60)) u2 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(we[2]), .mem_addr(addr[2]), .mem_wdata(wd[2]), .count(cnt[2]),
    .busy(bsy[2]), .done(dn[2]), .err(er[2]));

  int depth_p [NI] = '{64, 4, 8};
  int base_p  [NI] = '{0, 0, 60};

  // reference model: session phase 0 idle, 1 loading, 2 finished
  int          m_phase [NI];
  bit          m_we    [NI];
  int          m_addr  [NI];
  logic [31:0] m_wdata [NI];
  int          m_cnt   [NI];
  bit          m_err   [NI];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Word built from the architectural field layout of each format.
  function automatic logic [31:0] ref_encode(int cls, int rd, int rs1, int rs2,
                                             int f3, int f7, int imm);
    int off;
    int w;
    off = imm * 2;
    case (cls)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
      1: w = (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h03;
      2: w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | ((imm & 31) << 7) | 'h23;
      3: w = (((off >> 12) & 1) << 31) | (((off >> 5) & 63) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((off >> 1) & 15) << 8)
             | (((off >> 11) & 1) << 7) | 'h63;
      4: w = (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        m_phase[k] = 0; m_we[k] = 0; m_addr[k] = 0; m_wdata[k] = 0;
        m_cnt[k] = 0; m_err[k] = 0;
      end else begin
        m_we[k] = 0;
        if (m_phase[k] != 1) begin
          if (start) begin
            m_phase[k] = 1; m_cnt[k] = 0; m_err[k] = 0;
          end
        end else if (in_valid) begin
          if (in_class < 5) begin
            m_we[k]    = 1;
            m_addr[k]  = (base_p[k] + m_cnt[k]) % (1 << AW);
            m_wdata[k] = ref_encode(in_class, in_rd, in_rs1, in_rs2, in_funct3,
                                    in_funct7, in_imm);
            m_cnt[k]++;
            if (in_last || m_cnt[k] == depth_p[k]) m_phase[k] = 2;
          end else begin
            m_err[k] = 1;
            if (in_last) m_phase[k] = 2;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.in_ready", k), rdy[k], m_phase[k] == 1);
      chk($sformatf("u%0d.busy", k), bsy[k], m_phase[k] == 1);
      chk($sformatf("u%0d.done", k), dn[k], m_phase[k] == 2);
      chk($sformatf("u%0d.mem_we", k), we[k], m_we[k]);
      chk($sformatf("u%0d.mem_addr", k), addr[k], m_addr[k]);
      chk($sformatf("u%0d.mem_wdata", k), wd[k], m_wdata[k]);
      chk($sformatf("u%0d.count", k), cnt[k], m_cnt[k]);
      chk($sformatf("u%0d.err", k), er[k], m_err[k]);
    end
  endtask

  // inputs are already applied; predict the coming edge, then sample at the falling edge
  task automatic cycle();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_fields();
    in_rd     = 5'($urandom);
    in_rs1    = 5'($urandom);
    in_rs2    = 5'($urandom);
    in_funct3 = 3'($urandom);
    in_funct7 = 7'($urandom);
    in_imm    = 12'($urandom);
    in_class  = ($urandom % 8 < 2) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    in_last   = ($urandom % 16 == 0);
  endtask

  task automatic idle();
    reset = 0; start = 0; in_valid = 0;
    rand_fields();
  endtask

  task automatic set_desc(input int cls, input int rd, input int rs1, input int rs2,
                          input int f3, input int f7, input int imm, input bit last);
    reset = 0; start = 0; in_valid = 1;
    in_class = 3'(cls); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = 12'(imm); in_last = last;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_phase[k] = 0; m_we[k] = 0; m_addr[k] = 0; m_wdata[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
    end
    reset = 1; start = 0; in_valid = 0;
    rand_fields();

    // reset holds everything at zero whatever the other inputs do
    repeat (5) begin
      rand_fields();
      start = $urandom % 2; in_valid = $urandom % 2; reset = 1;
      cycle();
      chk("reset.mem_we", we[0], 0);
      chk("reset.in_ready", rdy[0], 0);
    end

    // first session on u0: R, LOAD, STORE, BRANCH back to back
    idle(); start = 1; cycle();
    set_desc(0, 3, 1, 2, 0, 0, 0, 0); cycle();
    chk("r.word", wd[0], 32'h002081B3); chk("r.addr", addr[0], 0);
    chk("r.we", we[0], 1); chk("r.count", cnt[0], 1);
    set_desc(1, 5, 2, 0, 2, 0, 8, 0); cycle();
    chk("ld.word", wd[0], 32'h00812283); chk("ld.addr", addr[0], 1);
    set_desc(2, 0, 2, 5, 2, 0, 12, 0); cycle();
    chk("st.word", wd[0], 32'h00512623); chk("st.addr", addr[0], 2); chk("st.we", we[0], 1);
    set_desc(3, 0, 1, 2, 0, 0, 'hFFE, 1); cycle();
    chk("br.word", wd[0], 32'hFE208EE3); chk("br.addr", addr[0], 3);
    idle(); cycle();
    chk("end.done", dn[0], 1); chk("end.in_ready", rdy[0], 0);
    chk("end.count", cnt[0], 4); chk("end.mem_we", we[0], 0);

    // invalid class with in_last closes the session without writing
    idle(); start = 1; cycle();
    set_desc(6, 1, 1, 1, 1, 1, 1, 1); cycle();
    chk("bad.mem_we", we[0], 0);
    idle(); cycle();
    chk("bad.err", er[0], 1); chk("bad.count", cnt[0], 0); chk("bad.done", dn[0], 1);

    // four IALU descriptors fill the DEPTH=4 instance
    idle(); start = 1; cycle();
    for (int i = 0; i < 4; i++) begin
      set_desc(4, i + 1, 2, 0, 0, 0, i * 3, 0); cycle();
      chk("d4.we", we[1], 1); chk("d4.addr", addr[1], i);
    end
    idle(); cycle();
    chk("d4.done", dn[1], 1); chk("d4.in_ready", rdy[1], 0); chk("d4.count", cnt[1], 4);
    chk("d4.u0_busy", bsy[0], 1);

    // same stream aborted by reset after two accepts
    idle(); reset = 1; cycle();
    idle(); start = 1; cycle();
    for (int i = 0; i < 2; i++) begin
      set_desc(4, i + 7, 3, 0, 1, 0, i, 0); cycle();
    end
    set_desc(4, 9, 3, 0, 1, 0, 2, 0); reset = 1; cycle();
    chk("abort.we", we[1], 0); chk("abort.count", cnt[1], 0); chk("abort.busy", bsy[1], 0);
    reset = 1; cycle();
    idle(); cycle();
    chk("abort.idle_we", we[1], 0); chk("abort.idle_done", dn[1], 0);
    chk("abort.idle_wdata", wd[1], 0);

    // randomized traffic
    repeat (3000) begin
      rand_fields();
      reset    = ($urandom % 64 == 0);
      start    = ($urandom % 8 == 0);
      in_valid = ($urandom % 4 != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
